// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, limits and address decode for the APB completer
// Purpose: state encoding, wait-state limit, data width and the address error rule
// used by apb_slave_mem. No ports.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } apb_slv_state_e;

    localparam int APB_MAX_WAIT = 5;
    localparam int APB_DATA_W   = 32;

    // Arguments are widened to 64 bits so the rule works for any address width
    // without wrap-around in the index comparison.
    function automatic logic apb_addr_err(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] depth
    );
        logic [63:0] offset;
        offset = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((offset >> 2) >= depth);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - word memory with synchronous clear, one write and one read port
// Purpose: register-file storage behind the APB completer.
// Ports:
//   i_clk    - clock
//   i_rst    - synchronous active-high reset, clears every word
//   i_we     - write enable
//   i_widx   - write word index
//   i_wdata  - write data
//   i_ridx   - read word index
//   o_rdata  - combinational read data for i_ridx
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_ridx,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer fronting a word memory with fixed wait states
// Purpose: terminates APB transfers with a registered pready after WAIT_CYCLES
// access-phase wait states, error response on bad addresses.
// Ports:
//   pclk, rst              - clock, synchronous active-high reset
//   paddr, pwdata, pwrite  - request, captured in the setup cycle
//   psel, penable          - APB phase control
//   prdata, pready, pslverr- registered response, zero outside the pready cycle
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = APB_DATA_W,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pwrite,
    input  logic                  psel,
    input  logic                  penable,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 3;
    // SETUP is the first access cycle, so the counter covers the remaining waits.
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > APB_MAX_WAIT) begin : g_bad_wait
        $error("apb_slave_mem: WAIT_CYCLES must be within 0..5");
    end
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_slave_mem: DEPTH must be a power of two");
    end

    apb_slv_state_e        r_state, w_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic                  r_pready, r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    logic                  w_setup, w_resp, w_write, w_err, w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [IDX_W-1:0]      w_idx, w_widx;
    logic [DATA_WIDTH-1:0] w_mem_rdata, w_rd_data;

    assign w_setup = psel && !penable && (r_state == IDLE || r_state == DONE);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE, DONE: begin
                if (w_setup) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = DONE;
                    end else begin
                        w_next     = SETUP;
                        w_cnt_next = CNT_LOAD;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            SETUP, WAIT: begin
                if (!psel) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt != '0) begin
                    w_next     = WAIT;
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (penable) begin
                    w_next = DONE;
                end else begin
                    w_next = WAIT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The response is registered one edge ahead of DONE; with zero wait states
    // that edge is the setup edge itself, so decode straight from the bus.
    assign w_resp  = (w_next == DONE);
    assign w_addr  = w_setup ? paddr : r_addr;
    assign w_write = w_setup ? pwrite : r_write;
    assign w_err   = apb_addr_err(64'(w_addr), 64'(BASE_ADDR), 64'(DEPTH));
    assign w_idx   = IDX_W'((w_addr - BASE_ADDR) >> 2);

    assign w_we    = (r_state == DONE) && r_write && !r_pslverr;
    assign w_widx  = IDX_W'((r_addr - BASE_ADDR) >> 2);

    // A read sampled on the same edge that commits a write sees the new word.
    assign w_rd_data = (w_we && (w_widx == w_idx)) ? r_wdata : w_mem_rdata;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_pready  <= w_resp;
            r_pslverr <= w_resp && w_err;
            r_prdata  <= (w_resp && !w_write && !w_err) ? w_rd_data : '0;
            if (w_setup) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
            end
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .i_clk   (pclk),
        .i_rst   (rst),
        .i_we    (w_we),
        .i_widx  (w_widx),
        .i_wdata (r_wdata),
        .i_ridx  (w_idx),
        .o_rdata (w_mem_rdata)
    );

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - randomized self-checking bench for apb_slave_mem, WAIT_CYCLES 0..5
module tb_apb_slave_mem;

    localparam int NI = 6;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    logic        psel_a    [NI];
    logic        penable_a [NI];
    logic        pwrite_a  [NI];
    logic [31:0] paddr_a   [NI];
    logic [31:0] pwdata_a  [NI];
    logic [31:0] prdata_a  [NI];
    logic        pready_a  [NI];
    logic        pslverr_a [NI];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cur   = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q [$];
    logic [31:0] mem_m [NI][256];
    int          wait_run [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_slave_mem #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .DEPTH       (256),
            .BASE_ADDR   ((g == 3) ? 32'h0000_1000 : 32'h0000_0000),
            .WAIT_CYCLES (g)
        ) u_dut (
            .pclk    (pclk),
            .rst     (rst),
            .paddr   (paddr_a[g]),
            .pwdata  (pwdata_a[g]),
            .pwrite  (pwrite_a[g]),
            .psel    (psel_a[g]),
            .penable (penable_a[g]),
            .prdata  (prdata_a[g]),
            .pready  (pready_a[g]),
            .pslverr (pslverr_a[g])
        );
    end

    function automatic logic [31:0] base_of(input int g);
        return (g == 3) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    // Reference: error rule and memory effect of one completed transfer.
    function automatic void model(input int g, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] data, output logic err,
                                  output logic [31:0] rd);
        logic [31:0] base;
        logic [31:0] off;
        base = base_of(g);
        off  = addr - base;
        err  = (addr[1:0] != 2'b00) || (addr < base) || ((off / 4) >= 256);
        rd   = 32'h0;
        if (!err) begin
            if (wr) mem_m[g][off[9:2]] = data;
            else    rd = mem_m[g][off[9:2]];
        end
    endfunction

    function automatic void model_clear();
        for (int g = 0; g < NI; g++)
            for (int i = 0; i < 256; i++)
                mem_m[g][i] = 32'h0;
    endfunction

    always @(posedge pclk) cyc <= cyc + 1;

    // Per-cycle compare of every instance against the expectation queue.
    always @(negedge pclk) begin
        logic        er, ee;
        logic [31:0] ed;
        if (cyc >= 1) begin
            for (int g = 0; g < NI; g++) begin
                er = 1'b0;
                ee = 1'b0;
                ed = 32'h0;
                if (g == cur && q.size() > 0 && q[0].cyc == cyc) begin
                    er = 1'b1;
                    ee = q[0].err;
                    ed = q[0].data;
                    void'(q.pop_front());
                end
                tests++;
                if (pready_a[g] !== er || pslverr_a[g] !== ee || prdata_a[g] !== ed) begin
                    fails++;
                    $display("FAIL cycle_check inst=%0d cyc=%0d got rdy=%b err=%b data=%h exp rdy=%b err=%b data=%h",
                             g, cyc, pready_a[g], pslverr_a[g], prdata_a[g], er, ee, ed);
                end
                if (psel_a[g] && penable_a[g] && !pready_a[g]) begin
                    wait_run[g]++;
                end else begin
                    if (psel_a[g] && penable_a[g]) tests++;
                    wait_run[g] = 0;
                end
                if (wait_run[g] > 5) begin
                    fails++;
                    $display("FAIL ready_window inst=%0d cyc=%0d got %0d access cycles without pready, exp <=5",
                             g, cyc, wait_run[g]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout got no finish by time limit, exp finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int g, input int n);
        psel_a[g]    = 1'b0;
        penable_a[g] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Entered at the setup cycle; returns at the cycle after pready with the
    // bus still in access phase, so the caller may start the next setup at once.
    task automatic xfer(input int g, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic o_rdy,
                        output logic o_err, output logic [31:0] o_data);
        logic        e;
        logic [31:0] rd;
        exp_t        x;
        model(g, wr, addr, data, e, rd);
        x.cyc  = cyc + 1 + g;
        x.err  = e;
        x.data = rd;
        q.push_back(x);
        psel_a[g]    = 1'b1;
        penable_a[g] = 1'b0;
        pwrite_a[g]  = wr;
        paddr_a[g]   = addr;
        pwdata_a[g]  = data;
        tick();
        penable_a[g] = 1'b1;
        paddr_a[g]   = $urandom;
        pwdata_a[g]  = $urandom;
        pwrite_a[g]  = 1'($urandom_range(0, 1));
        repeat (g) tick();
        o_rdy  = pready_a[g];
        o_err  = pslverr_a[g];
        o_data = prdata_a[g];
        tick();
    endtask

    task automatic abort_xfer(input int g, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input int j);
        psel_a[g]    = 1'b1;
        penable_a[g] = 1'b0;
        pwrite_a[g]  = wr;
        paddr_a[g]   = addr;
        pwdata_a[g]  = data;
        tick();
        penable_a[g] = 1'b1;
        repeat (j) tick();
        idle(g, 2);
    endtask

    function automatic logic [31:0] rand_addr(input int g);
        logic [31:0] base;
        int          r;
        base = base_of(g);
        r    = $urandom_range(0, 9);
        if (r < 6)       return base + 32'(4 * $urandom_range(0, 15));
        else if (r == 6) return base + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
        else if (r == 7) return base + 32'(4 * $urandom_range(256, 300));
        else if (r == 8) return base + 32'h3FC;
        else if (base != 32'h0) return base - 32'(4 * $urandom_range(1, 4));
        else             return base + 32'h400;
    endfunction

    logic        o_r, o_e;
    logic [31:0] o_d;

    initial begin
        for (int g = 0; g < NI; g++) begin
            psel_a[g]    = 1'b0;
            penable_a[g] = 1'b0;
            pwrite_a[g]  = 1'b0;
            paddr_a[g]   = 32'h0;
            pwdata_a[g]  = 32'h0;
            wait_run[g]  = 0;
        end
        model_clear();
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_pready",  32'(pready_a[2]),  32'd0);
        chk("reset_pslverr", 32'(pslverr_a[2]), 32'd0);
        chk("reset_prdata",  prdata_a[2],       32'd0);

        // Directed, WAIT_CYCLES = 2
        cur = 2;
        xfer(2, 1'b0, 32'h0, 32'h0, o_r, o_e, o_d);
        chk("first_read_after_reset", o_d, 32'h0);
        xfer(2, 1'b1, 32'h10, 32'hDEAD_BEEF, o_r, o_e, o_d);
        chk("wr10_pready", 32'(o_r), 32'd1);
        chk("wr10_pslverr", 32'(o_e), 32'd0);
        xfer(2, 1'b0, 32'h10, 32'h0, o_r, o_e, o_d);
        chk("rd10_prdata", o_d, 32'hDEAD_BEEF);
        chk("rd10_pslverr", 32'(o_e), 32'd0);
        idle(2, 1);
        xfer(2, 1'b0, 32'h13, 32'h0, o_r, o_e, o_d);
        chk("rd13_pslverr", 32'(o_e), 32'd1);
        chk("rd13_prdata", o_d, 32'h0);
        xfer(2, 1'b1, 32'h400, 32'h5A5A_5A5A, o_r, o_e, o_d);
        chk("wr400_pslverr", 32'(o_e), 32'd1);
        xfer(2, 1'b0, 32'h0, 32'h0, o_r, o_e, o_d);
        chk("rd0_after_oob_write", o_d, 32'h0);
        xfer(2, 1'b0, 32'h3FC, 32'h0, o_r, o_e, o_d);
        chk("rd3fc_last_word_ok", 32'(o_e), 32'd0);
        abort_xfer(2, 1'b1, 32'h8, 32'hAAAA_5555, 1);
        xfer(2, 1'b0, 32'h8, 32'h0, o_r, o_e, o_d);
        chk("rd8_after_abort", o_d, 32'h0);
        idle(2, 1);
        psel_a[2] = 1'b1;
        penable_a[2] = 1'b1;
        paddr_a[2] = 32'h10;
        pwrite_a[2] = 1'b0;
        tick();
        idle(2, 3);

        // Reset during the wait of a write: dropped, memory cleared.
        psel_a[2]    = 1'b1;
        penable_a[2] = 1'b0;
        pwrite_a[2]  = 1'b1;
        paddr_a[2]   = 32'h20;
        pwdata_a[2]  = 32'h1234;
        tick();
        penable_a[2] = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_mid_pready",  32'(pready_a[2]),  32'd0);
        chk("rst_mid_pslverr", 32'(pslverr_a[2]), 32'd0);
        chk("rst_mid_prdata",  prdata_a[2],       32'd0);
        rst = 1'b0;
        q.delete();
        model_clear();
        idle(2, 1);
        xfer(2, 1'b0, 32'h20, 32'h0, o_r, o_e, o_d);
        chk("rd20_after_reset", o_d, 32'h0);
        xfer(2, 1'b0, 32'h10, 32'h0, o_r, o_e, o_d);
        chk("rd10_cleared_by_reset", o_d, 32'h0);
        idle(2, 2);

        // Back-to-back at WAIT_CYCLES = 0
        cur = 0;
        xfer(0, 1'b1, 32'h4, 32'h1, o_r, o_e, o_d);
        xfer(0, 1'b0, 32'h4, 32'h0, o_r, o_e, o_d);
        chk("b2b_w0_pready", 32'(o_r), 32'd1);
        chk("b2b_w0_prdata", o_d, 32'h1);
        idle(0, 2);

        // Randomized traffic on every wait-state setting
        for (int g = 0; g < NI; g++) begin
            cur = g;
            for (int n = 0; n < 40; n++) begin
                if (g > 0 && $urandom_range(0, 7) == 0) begin
                    abort_xfer(g, 1'($urandom_range(0, 1)), rand_addr(g), $urandom,
                               $urandom_range(0, g - 1));
                end else begin
                    xfer(g, 1'($urandom_range(0, 1)), rand_addr(g), $urandom, o_r, o_e, o_d);
                    if ($urandom_range(0, 1) == 1) idle(g, 1);
                end
            end
            idle(g, 2);
        end

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations got %0d left, exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
